// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: fetch end of the SISC control interface.
// Owns the program counter and instruction register. It performs ctrl's
// ir_load / pc_write / pc_sel / br_sel / pc_rst commands against a
// req/ack instruction memory. A fetch that waits too long for an ack
// latches a sticky timeout fault, and only pc_rst or rst clears it.
module sisc_fetch_unit #(
    parameter int                ADDR_W  = 16,
    parameter int                INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RST_PC  = '0,
    parameter int                TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ir_load,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               pc_rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_busy,
    output logic               fetch_done,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fetch_done_q, fetch_done_d;
    logic               fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0]  next_pc;

    // Next-PC select. Sequential: pc+1. Absolute: IR[15:0] zero-extended or
    // truncated to ADDR_W. Relative: pc plus sign-extended IR[15:0]. All
    // results wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] cur_pc,
        input logic [15:0]       imm,
        input logic              sel,
        input logic              br
    );
        logic signed [15:0]       imm_s;
        logic signed [ADDR_W-1:0] rel_off;
        logic [ADDR_W-1:0]        result;
        imm_s   = $signed(imm);
        rel_off = ADDR_W'(imm_s);
        if (!sel) begin
            result = cur_pc + ADDR_W'(1);
        end else if (!br) begin
            result = ADDR_W'(imm);
        end else begin
            result = cur_pc + $unsigned(rel_off);
        end
        return result;
    endfunction

    // Next PC always comes from the current pc and the current (old) ir.
    always_comb begin
        next_pc = calc_next_pc(pc_q, ir_q[15:0], pc_sel, br_sel);
    end

    // FSM next-state, fetch datapath and PC update. pc_rst takes priority
    // over everything else.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cnt_d        = cnt_q;
        fetch_done_d = 1'b0;
        fetch_err_d  = fetch_err_q;

        // pc_write works in any state. A fetch already in flight keeps the
        // address it latched.
        if (pc_write) begin
            pc_d = next_pc;
        end

        unique case (state_q)
            ST_IDLE: begin
                mem_req_d = 1'b0;
                if (ir_load) begin
                    state_d    = ST_REQ;
                    mem_addr_d = pc_q;
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ir_d         = mem_rdata;
                    fetch_done_d = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_ERR;
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                // Parked until pc_rst. Loads and stray acks are ignored.
                mem_req_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A restart aborts any fetch and clears the fault. ir keeps its value.
        if (pc_rst) begin
            pc_d         = RST_PC;
            state_d      = ST_IDLE;
            ir_d         = ir_q;
            mem_req_d    = 1'b0;
            cnt_d        = '0;
            fetch_done_d = 1'b0;
            fetch_err_d  = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RST_PC;
            ir_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            fetch_done_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
            fetch_done_q <= fetch_done_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign pc         = pc_q;
    assign fetch_busy = (state_q == ST_REQ);
    assign fetch_done = fetch_done_q;
    assign fetch_err  = fetch_err_q;

endmodule
